// File: rtl/vga_bank_refresh_sequencer.sv
// Copies a window of the shared system register file into the VGA pointer display bank,
// one sweep per VSync falling edge, using a single req/gnt read port on the file's arbiter.
module vga_bank_refresh_sequencer #(
  parameter logic [7:0]  FIRST_ADDR  = 8'd40,
  parameter logic [7:0]  LAST_ADDR   = 8'd51,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Enable,
  input  logic       VSync,
  output logic       BusReq,
  input  logic       BusGnt,
  output logic [7:0] BusAddr,
  input  logic [7:0] BusData,
  output logic [7:0] MemAddrOut,
  output logic [7:0] MemDataOut,
  output logic       Write,
  output logic       Busy,
  output logic       SweepDone,
  output logic       SweepAbort,
  output logic [7:0] FrameCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WR
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT);
  localparam logic [7:0] TMO_LAST = 8'(GNT_TIMEOUT);

  state_t     state_q, state_d;
  logic       vsync_q, vsync_d;
  logic [7:0] cur_q, cur_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       bus_req_q, bus_req_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic       write_q, write_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    vsync_d     = VSync;
    cur_d       = cur_q;
    lat_cnt_d   = lat_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    write_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (state_q != S_IDLE && VSync) begin
      // The display bank is locked while VSync is high; any grant already taken is dropped.
      state_d = S_IDLE;
      abort_d = 1'b1;
      cur_d   = FIRST_ADDR;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cur_d = FIRST_ADDR;
          if (Enable && !VSync && vsync_q) begin
            state_d   = S_REQ;
            tmo_cnt_d = 8'd0;
          end
        end
        S_REQ: begin
          if (BusGnt) begin
            state_d   = S_WAIT;
            lat_cnt_d = 3'd1;
          end else if ((tmo_cnt_q + 8'd1) == TMO_LAST) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
            cur_d   = FIRST_ADDR;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == LAT_LAST) begin
            state_d    = S_WR;
            write_d    = 1'b1;
            mem_addr_d = cur_q;
            mem_data_d = BusData;
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        S_WR: begin
          // Compare before incrementing so LAST_ADDR=255 never wraps into address 0.
          if (cur_q == LAST_ADDR) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            cur_d       = FIRST_ADDR;
          end else begin
            state_d   = S_REQ;
            cur_d     = cur_q + 8'd1;
            tmo_cnt_d = 8'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    bus_req_d  = (state_d == S_REQ);
    bus_addr_d = bus_req_d ? cur_d : 8'd0;
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b1;
      cur_q       <= FIRST_ADDR;
      lat_cnt_q   <= 3'd0;
      tmo_cnt_q   <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= 8'd0;
      write_q     <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_data_q  <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      cur_q       <= cur_d;
      lat_cnt_q   <= lat_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      write_q     <= write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // NOTE: the strobe is gated with live VSync so a VSync rise during the write cycle can never
  // reach the bank; a registered strobe alone could not react within that cycle.
  assign Write      = write_q & ~VSync;
  assign BusReq     = bus_req_q;
  assign BusAddr    = bus_addr_q;
  assign MemAddrOut = mem_addr_q;
  assign MemDataOut = mem_data_q;
  assign Busy       = busy_q;
  assign SweepDone  = done_q;
  assign SweepAbort = abort_q;
  assign FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_vga_bank_refresh_sequencer.sv
// Bench for vga_bank_refresh_sequencer: a transaction-level model (cycles since grant, word
// index) is compared against the DUT every cycle, plus directed literal checks per scenario.
module tb_vga_bank_refresh_sequencer;

  localparam int RL    = 1;
  localparam int TMO   = 4;
  localparam int FIRST = 40;
  localparam int LAST  = 51;

  logic       CLK = 1'b0;
  logic       RESET, Enable, VSync, BusGnt;
  logic [7:0] BusData;
  logic       BusReq, Write, Busy, SweepDone, SweepAbort;
  logic [7:0] BusAddr, MemAddrOut, MemDataOut, FrameCount;

  vga_bank_refresh_sequencer #(
    .FIRST_ADDR (8'd40),
    .LAST_ADDR  (8'd51),
    .READ_LAT   (RL),
    .GNT_TIMEOUT(TMO)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Enable    (Enable),
    .VSync     (VSync),
    .BusReq    (BusReq),
    .BusGnt    (BusGnt),
    .BusAddr   (BusAddr),
    .BusData   (BusData),
    .MemAddrOut(MemAddrOut),
    .MemDataOut(MemDataOut),
    .Write     (Write),
    .Busy      (Busy),
    .SweepDone (SweepDone),
    .SweepAbort(SweepAbort),
    .FrameCount(FrameCount)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Arbiter/file stimulus: 0 = grant always, 1 = grant after 3 waiting cycles, 2 = never grant.
  int         gnt_mode = 0;
  int         gnt_age  = 0;
  bit         gnt_hit  = 0;
  logic [7:0] hit_addr = 8'd0;

  // Behavioural model: a sweep is a word index plus "cycles since grant" (-1 while requesting).
  bit         m_valid = 0;
  bit         m_active, m_prev_vs, m_wr, m_done, m_abort;
  int         m_addr, m_since, m_waits, m_frame;
  logic [7:0] m_maddr, m_mdata;

  // Monitor log
  int         wr_n = 0, done_n = 0, abort_n = 0, req_n = 0;
  int         done_cyc = 0, busy_rise_cyc = 0;
  bit         busy_prev = 0;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    m_done  = 0;
    m_abort = 0;
    m_wr    = 0;
    if (!RESET) begin
      m_valid   = 1;
      m_active  = 0;
      m_prev_vs = 1;
      m_frame   = 0;
      m_maddr   = 8'd0;
      m_mdata   = 8'd0;
    end else begin
      if (m_active && VSync) begin
        m_active = 0;
        m_abort  = 1;
      end else if (!m_active) begin
        if (Enable && !VSync && m_prev_vs) begin
          m_active = 1;
          m_addr   = FIRST;
          m_since  = -1;
          m_waits  = 0;
        end
      end else if (m_since < 0) begin
        if (BusGnt) m_since = 1;
        else begin
          m_waits++;
          if (m_waits == TMO) begin
            m_active = 0;
            m_abort  = 1;
          end
        end
      end else if (m_since <= RL) begin
        m_since++;
        if (m_since == RL + 1) begin
          m_wr    = 1;
          m_maddr = 8'(m_addr);
          m_mdata = 8'(m_addr) ^ 8'hA5;
        end
      end else begin
        if (m_addr == LAST) begin
          m_active = 0;
          m_done   = 1;
          m_frame  = (m_frame + 1) % 256;
        end else begin
          m_addr++;
          m_since = -1;
          m_waits = 0;
        end
      end
      m_prev_vs = VSync;
    end
  endtask

  // One clock: update model at the edge, drive read data, compare #1 later, then drive grant.
  task automatic step();
    bit exp_req;
    @(posedge CLK);
    model_update();
    if (!RESET) gnt_hit = 0;
    else begin
      gnt_hit  = BusReq && BusGnt;
      hit_addr = BusAddr;
    end
    #1;
    BusData = gnt_hit ? (hit_addr ^ 8'hA5) : 8'hEE;
    cyc++;
    if (m_valid) begin
      exp_req = m_active && (m_since < 0);
      check($sformatf("c%0d BusReq", cyc), int'(BusReq), int'(exp_req));
      check($sformatf("c%0d BusAddr", cyc), int'(BusAddr), exp_req ? m_addr : 0);
      check($sformatf("c%0d Write", cyc), int'(Write), int'(m_wr && !VSync));
      check($sformatf("c%0d MemAddrOut", cyc), int'(MemAddrOut), int'(m_maddr));
      check($sformatf("c%0d MemDataOut", cyc), int'(MemDataOut), int'(m_mdata));
      check($sformatf("c%0d Busy", cyc), int'(Busy), int'(m_active));
      check($sformatf("c%0d SweepDone", cyc), int'(SweepDone), int'(m_done));
      check($sformatf("c%0d SweepAbort", cyc), int'(SweepAbort), int'(m_abort));
      check($sformatf("c%0d FrameCount", cyc), int'(FrameCount), m_frame);
    end
    if (Write === 1'b1) begin
      wr_n++;
      wr_addr_q.push_back(MemAddrOut);
      wr_data_q.push_back(MemDataOut);
      wr_cyc_q.push_back(cyc);
    end
    if (SweepDone === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    if (SweepAbort === 1'b1) abort_n++;
    if (BusReq === 1'b1) req_n++;
    if (Busy === 1'b1 && !busy_prev) busy_rise_cyc = cyc;
    busy_prev = (Busy === 1'b1);
    @(negedge CLK);
    case (gnt_mode)
      0: BusGnt = 1'b1;
      1: begin
        if (BusReq) begin
          BusGnt = (gnt_age >= 3);
          gnt_age++;
        end else begin
          BusGnt  = 1'b0;
          gnt_age = 0;
        end
      end
      default: BusGnt = 1'b0;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_n == base && k < budget) begin
      step();
      k++;
    end
    check({name, " sweep finished"}, int'(done_n != base), 1);
  endtask

  int b_wr, b_done, b_abort, b_req;

  task automatic snap();
    b_wr    = wr_n;
    b_done  = done_n;
    b_abort = abort_n;
    b_req   = req_n;
  endtask

  task automatic sweep_checks(input string name, input int spacing);
    check({name, " write count"}, wr_n - b_wr, 12);
    if (wr_n - b_wr == 12) begin
      check({name, " first addr"}, int'(wr_addr_q[b_wr]), 40);
      check({name, " first data"}, int'(wr_data_q[b_wr]), 8'h8D);
      check({name, " last addr"}, int'(wr_addr_q[b_wr + 11]), 51);
      check({name, " last data"}, int'(wr_data_q[b_wr + 11]), 8'h96);
      check({name, " spacing"}, wr_cyc_q[b_wr + 1] - wr_cyc_q[b_wr], spacing);
      check({name, " spacing end"}, wr_cyc_q[b_wr + 11] - wr_cyc_q[b_wr + 10], spacing);
    end
    check({name, " done pulses"}, done_n - b_done, 1);
  endtask

  initial begin
    RESET = 1'b0; Enable = 1'b0; VSync = 1'b1; BusGnt = 1'b1; BusData = 8'hEE;

    // 1: reset with VSync toggling
    for (int i = 0; i < 3; i++) begin
      VSync = ~VSync;
      step();
    end
    check("t1 Busy", int'(Busy), 0);
    check("t1 Write", int'(Write), 0);
    check("t1 BusReq", int'(BusReq), 0);
    check("t1 FrameCount", int'(FrameCount), 0);
    VSync = 1'b1;
    RESET = 1'b1;
    steps(2);

    // 2: immediate grant, full sweep
    Enable = 1'b1; gnt_mode = 0;
    snap();
    VSync = 1'b0;
    run_to_done(b_done, 200, "t2");
    sweep_checks("t2", 3);
    check("t2 done latency", done_cyc - busy_rise_cyc, 36);
    check("t2 FrameCount", int'(FrameCount), 1);
    VSync = 1'b1;
    steps(3);

    // 3: grant delayed 3 cycles per request
    gnt_mode = 1;
    snap();
    VSync = 1'b0;
    run_to_done(b_done, 300, "t3");
    sweep_checks("t3", 6);
    check("t3 FrameCount", int'(FrameCount), 2);
    VSync = 1'b1;
    steps(3);

    // 4: VSync rises after the 5th write
    gnt_mode = 0;
    snap();
    VSync = 1'b0;
    for (int k = 0; k < 100 && wr_n - b_wr < 5; k++) step();
    step();
    VSync = 1'b1;
    steps(6);
    check("t4 writes", wr_n - b_wr, 5);
    check("t4 aborts", abort_n - b_abort, 1);
    check("t4 FrameCount", int'(FrameCount), 2);
    VSync = 1'b0;
    step();
    check("t4 restart BusReq", int'(BusReq), 1);
    check("t4 restart BusAddr", int'(BusAddr), 40);
    snap();
    run_to_done(b_done, 200, "t4");
    check("t4 FrameCount after", int'(FrameCount), 3);
    VSync = 1'b1;
    steps(3);

    // 5: grant stuck low, timeout of 4
    gnt_mode = 2;
    snap();
    VSync = 1'b0;
    steps(10);
    check("t5 BusReq cycles", req_n - b_req, 4);
    check("t5 aborts", abort_n - b_abort, 1);
    check("t5 writes", wr_n - b_wr, 0);
    check("t5 Busy", int'(Busy), 0);
    VSync = 1'b1;
    steps(3);

    // 6a: Enable low at the edge
    gnt_mode = 0; Enable = 1'b0;
    snap();
    VSync = 1'b0;
    steps(5);
    check("t6 no BusReq", req_n - b_req, 0);
    check("t6 idle Busy", int'(Busy), 0);
    VSync = 1'b1;
    steps(2);

    // 6b: reset during WAIT of word 7
    Enable = 1'b1;
    snap();
    VSync = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (wr_n - b_wr == 6 && Busy === 1'b1 && BusReq === 1'b0 && Write === 1'b0) break;
    end
    check("t6 reached word 7 wait", int'(wr_n - b_wr == 6 && Busy === 1'b1 && BusReq === 1'b0), 1);
    RESET = 1'b0;
    VSync = 1'b1;
    step();
    check("t6 rst Busy", int'(Busy), 0);
    check("t6 rst BusReq", int'(BusReq), 0);
    check("t6 rst Write", int'(Write), 0);
    check("t6 rst SweepAbort", int'(SweepAbort), 0);
    check("t6 rst FrameCount", int'(FrameCount), 0);
    check("t6 rst MemAddrOut", int'(MemAddrOut), 0);
    RESET = 1'b1;
    steps(3);
    check("t6 no abort pulse", abort_n - b_abort, 0);
    check("t6 writes", wr_n - b_wr, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
